// File: rtl/mem_stage.sv
// mem_stage: load/store access stage behind the ALU, registered writeback.
// Optional feature macro: MEM_STAGE_MISALIGN_TRAP_EN (misaligned H/W fault).
module mem_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_alu_z,
    input  logic [XLEN-1:0] in_addr,
    input  logic [XLEN-1:0] in_store_data,
    input  logic [2:0]      in_funct3,
    input  logic            in_memread,
    input  logic            in_memwrite,
    input  logic [4:0]      in_rd,
    input  logic            in_regwrite,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [3:0]      dmem_be,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_gnt,
    input  logic            dmem_rvalid,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            wb_valid,
    output logic            wb_regwrite,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            wb_fault,
    output logic [XLEN-1:0] wb_fault_addr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    state_t state_n;

    logic [1:0]      size;
    logic            is_mem;
    logic            illegal;
    logic            misalign;
    logic            fault;
    logic            accept;
    logic            go_mem;
    logic [3:0]      be_n;
    logic [XLEN-1:0] wdata_n;

    logic [4:0]      rd_q;
    logic            regwrite_q;
    logic [2:0]      funct3_q;
    logic [1:0]      off_q;

    logic [7:0]      byte_sel;
    logic [15:0]     half_sel;
    logic [XLEN-1:0] load_val;

    assign size    = in_funct3[1:0];
    assign is_mem  = in_memread | in_memwrite;
    assign illegal = (in_memread & in_memwrite)
                   | (is_mem & ((in_funct3 == 3'b011)
                              | (in_funct3 == 3'b110)
                              | (in_funct3 == 3'b111)));

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    assign misalign = is_mem & ~illegal
                    & (((size == 2'b01) & in_addr[0])
                     | ((size == 2'b10) & (|in_addr[1:0])));
`else
    assign misalign = 1'b0;
`endif

    assign fault  = illegal | misalign;
    assign accept = in_valid & in_ready;
    assign go_mem = accept & is_mem & ~fault;

    // Lane placement: byte enables and replicated store data by size.
    always_comb begin
        be_n    = 4'b1111;
        wdata_n = in_store_data;
        case (size)
            2'b00: begin
                be_n    = 4'b0001 << in_addr[1:0];
                wdata_n = {4{in_store_data[7:0]}};
            end
            2'b01: begin
                be_n    = in_addr[1] ? 4'b1100 : 4'b0011;
                wdata_n = {2{in_store_data[15:0]}};
            end
            default: begin
                be_n    = 4'b1111;
                wdata_n = in_store_data;
            end
        endcase
    end

    // Load data extraction: lane select then sign/zero extension.
    always_comb begin
        byte_sel = dmem_rdata[7:0];
        case (off_q)
            2'd0:    byte_sel = dmem_rdata[7:0];
            2'd1:    byte_sel = dmem_rdata[15:8];
            2'd2:    byte_sel = dmem_rdata[23:16];
            default: byte_sel = dmem_rdata[31:24];
        endcase
        half_sel = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (funct3_q)
            3'b000:  load_val = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_val = {24'd0, byte_sel};
            3'b101:  load_val = {16'd0, half_sel};
            default: load_val = dmem_rdata;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic.
    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (go_mem) begin
                    state_n = REQ;
                end
            end
            REQ: begin
                if (dmem_gnt) begin
                    state_n = dmem_we ? IDLE : RESP;
                end
            end
            RESP: begin
                if (dmem_rvalid) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Upstream handshake: ready only when idle and out of reset.
    always_comb begin
        in_ready = (state == IDLE) & rst_n;
    end

    // Bus request registers and the per-access context.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_be    <= 4'b0000;
            dmem_wdata <= '0;
            rd_q       <= 5'd0;
            regwrite_q <= 1'b0;
            funct3_q   <= 3'd0;
            off_q      <= 2'd0;
        end else if (go_mem) begin
            dmem_req   <= 1'b1;
            dmem_we    <= in_memwrite;
            dmem_addr  <= {in_addr[XLEN-1:2], 2'b00};
            dmem_be    <= be_n;
            dmem_wdata <= wdata_n;
            rd_q       <= in_rd;
            regwrite_q <= in_regwrite;
            funct3_q   <= in_funct3;
            off_q      <= in_addr[1:0];
        end else if ((state == REQ) && dmem_gnt) begin
            dmem_req <= 1'b0;
        end
    end

    // Writeback record: one-cycle pulse per retired op.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wb_valid      <= 1'b0;
            wb_regwrite   <= 1'b0;
            wb_rd         <= 5'd0;
            wb_data       <= '0;
            wb_fault      <= 1'b0;
            wb_fault_addr <= '0;
        end else begin
            wb_valid <= 1'b0;
            if (accept && (!is_mem || fault)) begin
                wb_valid    <= 1'b1;
                wb_rd       <= in_rd;
                wb_regwrite <= in_regwrite & ~fault;
                wb_data     <= fault ? '0 : in_alu_z;
                wb_fault    <= fault;
                if (fault) begin
                    wb_fault_addr <= in_addr;
                end
            end else if ((state == REQ) && dmem_gnt && dmem_we) begin
                wb_valid    <= 1'b1;
                wb_rd       <= rd_q;
                wb_regwrite <= 1'b0;
                wb_fault    <= 1'b0;
            end else if ((state == RESP) && dmem_rvalid) begin
                wb_valid    <= 1'b1;
                wb_rd       <= rd_q;
                wb_regwrite <= regwrite_q;
                wb_data     <= load_val;
                wb_fault    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: vector table, directed sequences and random ops
// checked against a lane-arithmetic reference model.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_alu_z;
    logic [31:0] in_addr;
    logic [31:0] in_store_data;
    logic [2:0]  in_funct3;
    logic        in_memread;
    logic        in_memwrite;
    logic [4:0]  in_rd;
    logic        in_regwrite;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        wb_valid;
    logic        wb_regwrite;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_fault;
    logic [31:0] wb_fault_addr;

    int checks = 0;
    int errors = 0;

    mem_stage #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_alu_z(in_alu_z), .in_addr(in_addr),
        .in_store_data(in_store_data), .in_funct3(in_funct3),
        .in_memread(in_memread), .in_memwrite(in_memwrite),
        .in_rd(in_rd), .in_regwrite(in_regwrite),
        .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_regwrite(wb_regwrite),
        .wb_rd(wb_rd), .wb_data(wb_data),
        .wb_fault(wb_fault), .wb_fault_addr(wb_fault_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] alu_z;
        logic [31:0] addr;
        logic [31:0] sd;
        logic [2:0]  f3;
        logic        mr;
        logic        mw;
        logic [4:0]  rd;
        logic        rw;
        logic [31:0] rdata;
        int          gd;
        int          rdl;
        logic        exp_mem;
        logic        exp_fault;
        logic        exp_we;
        logic        exp_rw;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_data;
    } vec_t;

    vec_t tbl [14];

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic chkw(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(
        input logic [31:0] alu_z, input logic [31:0] addr,
        input logic [31:0] sd, input logic [2:0] f3,
        input logic mr, input logic mw,
        input logic [4:0] rd, input logic rw,
        input logic [31:0] rdata, input int gd, input int rdl,
        input logic em, input logic ef, input logic ewe, input logic erw,
        input logic [31:0] eaddr, input logic [3:0] ebe,
        input logic [31:0] ewd, input logic [31:0] edata);
        vec_t v;
        v.alu_z = alu_z; v.addr = addr; v.sd = sd; v.f3 = f3;
        v.mr = mr; v.mw = mw; v.rd = rd; v.rw = rw;
        v.rdata = rdata; v.gd = gd; v.rdl = rdl;
        v.exp_mem = em; v.exp_fault = ef; v.exp_we = ewe; v.exp_rw = erw;
        v.exp_addr = eaddr; v.exp_be = ebe;
        v.exp_wdata = ewd; v.exp_data = edata;
        return v;
    endfunction

    // Reference model: byte-lane arithmetic on the access size.
    function automatic vec_t model(input vec_t v);
        vec_t   r;
        logic   is_mem;
        logic   illegal;
        logic   mis;
        int     off;
        int     n;
        int     start;
        longint mask;
        longint val;
        r = v;
        is_mem  = v.mr || v.mw;
        illegal = (v.mr && v.mw) ||
                  (is_mem && (v.f3 == 3 || v.f3 == 6 || v.f3 == 7));
        off   = int'(v.addr % 32'd4);
        n     = 1 << v.f3[1:0];
        mis   = 1'b0;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
        mis = is_mem && !illegal && (off % n != 0);
`endif
        r.exp_fault = illegal || mis;
        r.exp_mem   = is_mem && !r.exp_fault;
        r.exp_we    = v.mw;
        r.exp_addr  = v.addr - 32'(off);
        start       = (n >= 4) ? 0 : (off / n) * n;
        r.exp_be    = 4'(((1 << n) - 1) << start);
        if (n == 1)
            r.exp_wdata = {24'd0, v.sd[7:0]} * 32'h01010101;
        else if (n == 2)
            r.exp_wdata = {16'd0, v.sd[15:0]} * 32'h00010001;
        else
            r.exp_wdata = v.sd;
        mask = (n >= 4) ? 64'hFFFFFFFF : ((64'd1 << (8 * n)) - 1);
        val  = (longint'(v.rdata) >> (8 * start)) & mask;
        if (!v.f3[2] && n < 4 && val >= (mask + 1) / 2)
            val = val - (mask + 1);
        r.exp_data = is_mem ? 32'(val) : v.alu_z;
        r.exp_rw   = (r.exp_fault || v.mw) ? 1'b0 : v.rw;
        return r;
    endfunction

    task automatic run_vec(input vec_t v, input bit junk, input string t);
        in_valid      = 1'b1;
        in_alu_z      = v.alu_z;
        in_addr       = v.addr;
        in_store_data = v.sd;
        in_funct3     = v.f3;
        in_memread    = v.mr;
        in_memwrite   = v.mw;
        in_rd         = v.rd;
        in_regwrite   = v.rw;
        chk1({t, "/ready_accept"}, in_ready, 1'b1);
        step();
        in_valid = 1'b0;
        if (!v.exp_mem) begin
            chk1({t, "/wb_valid"}, wb_valid, 1'b1);
            chk1({t, "/no_req"}, dmem_req, 1'b0);
            chk1({t, "/wb_fault"}, wb_fault, v.exp_fault);
            if (v.exp_fault) begin
                chkw({t, "/fault_addr"}, wb_fault_addr, v.addr);
                chk1({t, "/fault_rw"}, wb_regwrite, 1'b0);
            end else begin
                chkw({t, "/wb_data"}, wb_data, v.exp_data);
                chkw({t, "/wb_rd"}, 32'(wb_rd), 32'(v.rd));
                chk1({t, "/wb_rw"}, wb_regwrite, v.exp_rw);
            end
        end else begin
            chk1({t, "/req"}, dmem_req, 1'b1);
            chkw({t, "/addr"}, dmem_addr, v.exp_addr);
            chkw({t, "/be"}, 32'(dmem_be), 32'(v.exp_be));
            chk1({t, "/we"}, dmem_we, v.exp_we);
            if (v.mw) chkw({t, "/wdata"}, dmem_wdata, v.exp_wdata);
            chk1({t, "/ready_req"}, in_ready, 1'b0);
            chk1({t, "/wb_early"}, wb_valid, 1'b0);
            for (int i = 0; i < v.gd; i++) begin
                if (junk) begin
                    dmem_rvalid = 1'($urandom_range(0, 1));
                    dmem_rdata  = $urandom;
                end
                step();
                chk1({t, "/req_hold"}, dmem_req, 1'b1);
                chkw({t, "/addr_hold"}, dmem_addr, v.exp_addr);
                chk1({t, "/ready_wait"}, in_ready, 1'b0);
                chk1({t, "/wb_wait"}, wb_valid, 1'b0);
            end
            dmem_rvalid = 1'b0;
            dmem_gnt    = 1'b1;
            step();
            dmem_gnt = 1'b0;
            chk1({t, "/req_drop"}, dmem_req, 1'b0);
            if (v.mw) begin
                chk1({t, "/st_wb"}, wb_valid, 1'b1);
                chk1({t, "/st_rw"}, wb_regwrite, 1'b0);
                chk1({t, "/st_fault"}, wb_fault, 1'b0);
                chk1({t, "/st_ready"}, in_ready, 1'b1);
            end else begin
                chk1({t, "/ld_nowb"}, wb_valid, 1'b0);
                chk1({t, "/ld_ready"}, in_ready, 1'b0);
                for (int i = 1; i < v.rdl; i++) begin
                    if (junk) dmem_gnt = 1'($urandom_range(0, 1));
                    step();
                    chk1({t, "/resp_wait"}, wb_valid, 1'b0);
                    chk1({t, "/resp_ready"}, in_ready, 1'b0);
                end
                dmem_gnt    = 1'b0;
                dmem_rvalid = 1'b1;
                dmem_rdata  = v.rdata;
                step();
                dmem_rvalid = 1'b0;
                chk1({t, "/ld_wb"}, wb_valid, 1'b1);
                chkw({t, "/ld_data"}, wb_data, v.exp_data);
                chkw({t, "/ld_rd"}, 32'(wb_rd), 32'(v.rd));
                chk1({t, "/ld_rw"}, wb_regwrite, v.exp_rw);
                chk1({t, "/ld_fault"}, wb_fault, 1'b0);
                chk1({t, "/ld_ready_wb"}, in_ready, 1'b1);
            end
        end
        step();
        chk1({t, "/wb_once"}, wb_valid, 1'b0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] zs [3];
        logic [2:0]  lf [5];
        logic [2:0]  bf [3];
        vec_t        v;
        int          k;

        zs[0] = 32'h11; zs[1] = 32'h22; zs[2] = 32'h33;
        lf[0] = 3'd0; lf[1] = 3'd1; lf[2] = 3'd2; lf[3] = 3'd4; lf[4] = 3'd5;
        bf[0] = 3'd3; bf[1] = 3'd6; bf[2] = 3'd7;

        //            alu_z         addr          sd            f3 mr mw rd rw rdata      gd rdl em ef we rw eaddr   be       wdata         data
        tbl[0]  = mk(0,            32'h1002, 32'hAABBCCDD, 3'd0, 0, 1, 5, 0, 0,            0, 1, 1, 0, 1, 0, 32'h1000, 4'b0100, 32'hDDDDDDDD, 0);
        tbl[1]  = mk(0,            32'h2003, 0,            3'd0, 1, 0, 6, 1, 32'h80FF7F01, 2, 3, 1, 0, 0, 1, 32'h2000, 4'b1000, 0, 32'hFFFFFF80);
        tbl[2]  = mk(0,            32'h2003, 0,            3'd4, 1, 0, 6, 1, 32'h80FF7F01, 2, 3, 1, 0, 0, 1, 32'h2000, 4'b1000, 0, 32'h00000080);
        tbl[3]  = mk(0,            32'h2002, 0,            3'd1, 1, 0, 8, 1, 32'h8001ABCD, 0, 1, 1, 0, 0, 1, 32'h2000, 4'b1100, 0, 32'hFFFF8001);
        tbl[4]  = mk(0,            32'h2000, 0,            3'd2, 1, 0, 9, 1, 32'h8001ABCD, 1, 1, 1, 0, 0, 1, 32'h2000, 4'b1111, 0, 32'h8001ABCD);
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
        tbl[5]  = mk(0,            32'h3001, 0,            3'd2, 1, 0, 10, 1, 32'h12345678, 0, 1, 0, 1, 0, 0, 0,        0,       0, 0);
`else
        tbl[5]  = mk(0,            32'h3001, 0,            3'd2, 1, 0, 10, 1, 32'h12345678, 0, 1, 1, 0, 0, 1, 32'h3000, 4'b1111, 0, 32'h12345678);
`endif
        tbl[6]  = mk(0,            32'h1002, 32'h1234ABCD, 3'd1, 0, 1, 4, 1, 0,            3, 1, 1, 0, 1, 0, 32'h1000, 4'b1100, 32'hABCDABCD, 0);
        tbl[7]  = mk(0,            32'h1004, 32'hCAFEF00D, 3'd2, 0, 1, 4, 0, 0,            1, 1, 1, 0, 1, 0, 32'h1004, 4'b1111, 32'hCAFEF00D, 0);
        tbl[8]  = mk(0,            32'h2000, 0,            3'd5, 1, 0, 11, 1, 32'h1234F00D, 0, 2, 1, 0, 0, 1, 32'h2000, 4'b0011, 0, 32'h0000F00D);
        tbl[9]  = mk(0,            32'h2000, 0,            3'd1, 1, 0, 12, 1, 32'h1234F00D, 0, 2, 1, 0, 0, 1, 32'h2000, 4'b0011, 0, 32'hFFFFF00D);
        tbl[10] = mk(0,            32'h4000, 0,            3'd2, 1, 1, 13, 1, 0,            0, 1, 0, 1, 0, 0, 0,        0,       0, 0);
        tbl[11] = mk(0,            32'h4444, 0,            3'd3, 1, 0, 14, 1, 0,            0, 1, 0, 1, 0, 0, 0,        0,       0, 0);
        tbl[12] = mk(32'hDEADBEEF, 32'h5555, 0,            3'd2, 0, 0, 7, 1, 0,            0, 1, 0, 0, 0, 1, 0,        0,       0, 32'hDEADBEEF);
        tbl[13] = mk(0,            32'h2001, 0,            3'd0, 1, 0, 15, 1, 32'h80FF7F01, 0, 1, 1, 0, 0, 1, 32'h2000, 4'b0010, 0, 32'h0000007F);

        rst_n = 1'b0; in_valid = 1'b0; in_alu_z = '0; in_addr = '0;
        in_store_data = '0; in_funct3 = '0; in_memread = 1'b0;
        in_memwrite = 1'b0; in_rd = '0; in_regwrite = 1'b0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;

        repeat (3) step();
        chk1("rst/in_ready", in_ready, 1'b0);
        chk1("rst/dmem_req", dmem_req, 1'b0);
        chk1("rst/dmem_we", dmem_we, 1'b0);
        chk1("rst/wb_valid", wb_valid, 1'b0);
        chk1("rst/wb_regwrite", wb_regwrite, 1'b0);
        chk1("rst/wb_fault", wb_fault, 1'b0);
        chkw("rst/dmem_addr", dmem_addr, 32'h0);
        chkw("rst/dmem_be", 32'(dmem_be), 32'h0);
        chkw("rst/dmem_wdata", dmem_wdata, 32'h0);
        chkw("rst/wb_rd", 32'(wb_rd), 32'h0);
        chkw("rst/wb_data", wb_data, 32'h0);
        chkw("rst/wb_fault_addr", wb_fault_addr, 32'h0);
        rst_n = 1'b1;
        #1;
        chk1("rst/ready_after", in_ready, 1'b1);

        // Back-to-back ALU ops retire on consecutive cycles.
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_alu_z = zs[i]; in_rd = 5'(i + 1);
            in_regwrite = 1'b1; in_memread = 1'b0; in_memwrite = 1'b0;
            chk1($sformatf("b2b%0d/ready", i), in_ready, 1'b1);
            step();
            chk1($sformatf("b2b%0d/wb_valid", i), wb_valid, 1'b1);
            chkw($sformatf("b2b%0d/wb_data", i), wb_data, zs[i]);
            chkw($sformatf("b2b%0d/wb_rd", i), 32'(wb_rd), 32'(i + 1));
            chk1($sformatf("b2b%0d/no_req", i), dmem_req, 1'b0);
        end
        in_valid = 1'b0;
        step();
        chk1("b2b/wb_end", wb_valid, 1'b0);

        for (int i = 0; i < 14; i++)
            run_vec(tbl[i], 1'b0, $sformatf("vec%0d", i));

        // Reset while waiting for a load response.
        in_valid = 1'b1; in_addr = 32'h2000; in_funct3 = 3'd2;
        in_memread = 1'b1; in_memwrite = 1'b0; in_rd = 5'd9; in_regwrite = 1'b1;
        step();
        in_valid = 1'b0;
        dmem_gnt = 1'b1;
        step();
        dmem_gnt = 1'b0;
        chk1("mrst/in_resp", in_ready, 1'b0);
        rst_n = 1'b0;
        step();
        chk1("mrst/req", dmem_req, 1'b0);
        chk1("mrst/wb", wb_valid, 1'b0);
        chk1("mrst/ready_low", in_ready, 1'b0);
        rst_n = 1'b1;
        dmem_rvalid = 1'b1;
        dmem_rdata = 32'h55;
        step();
        dmem_rvalid = 1'b0;
        chk1("mrst/late_rvalid", wb_valid, 1'b0);
        chk1("mrst/ready", in_ready, 1'b1);
        chk1("mrst/req_after", dmem_req, 1'b0);
        run_vec(tbl[12], 1'b0, "mrst/next");

        // Random ops against the reference model.
        for (int i = 0; i < 200; i++) begin
            v = tbl[0];
            v.alu_z = $urandom; v.addr = $urandom; v.sd = $urandom;
            v.rd = 5'($urandom); v.rw = 1'($urandom);
            v.rdata = $urandom;
            v.gd = $urandom_range(0, 3); v.rdl = $urandom_range(1, 3);
            k = $urandom_range(0, 9);
            if (k <= 2) begin
                v.mr = 1'b0; v.mw = 1'b0; v.f3 = 3'($urandom);
            end else if (k <= 5) begin
                v.mr = 1'b1; v.mw = 1'b0; v.f3 = lf[$urandom_range(0, 4)];
            end else if (k <= 7) begin
                v.mr = 1'b0; v.mw = 1'b1; v.f3 = bf[0] - 3'($urandom_range(1, 3));
            end else if (k == 8) begin
                v.mr = 1'b1; v.mw = 1'b1; v.f3 = 3'($urandom);
            end else begin
                v.mr = 1'($urandom); v.mw = ~v.mr; v.f3 = bf[$urandom_range(0, 2)];
            end
            run_vec(model(v), 1'b1, $sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage directly downstream of the integer ALU. It consumes the ALU result (`Z`), the branch-target/address adder output (used as the effective address) and rs2 store data. It performs byte/half/word loads and stores over a request/grant/response data-memory bus, and presents a registered writeback record to the register-file write port. Non-memory ops pass through in one cycle; memory ops stall the upstream stage via `in_ready` until the access completes.

## Interface
- Parameters:
- `XLEN`, 32: data/address width; only 32 is supported.
- Ports:
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `in_valid` in 1: upstream holds a valid op.
- `in_ready` out 1: stage can accept; op transfers when `in_valid & in_ready`.
- `in_alu_z` in 32: ALU result, written back for non-memory ops.
- `in_addr` in 32: effective address from the address adder.
- `in_store_data` in 32: rs2 data.
- `in_funct3` in 3: access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU).
- `in_memread` in 1: load.
- `in_memwrite` in 1: store.
- `in_rd` in 5: destination register.
- `in_regwrite` in 1: op writes rd.
- `dmem_req` out 1: bus request.
- `dmem_we` out 1: 1 = store.
- `dmem_addr` out 32: word-aligned address, bits[1:0] = 0.
- `dmem_be` out 4: byte enables.
- `dmem_wdata` out 32: lane-replicated store data.
- `dmem_gnt` in 1: request accepted this cycle.
- `dmem_rvalid` in 1: load response valid.
- `dmem_rdata` in 32: load response word.
- `wb_valid` out 1: one-cycle writeback/retire pulse.
- `wb_regwrite` out 1: write `wb_data` to `wb_rd`.
- `wb_rd` out 5: destination register.
- `wb_data` out 32: writeback value.
- `wb_fault` out 1: op faulted; `wb_regwrite` forced 0.
- `wb_fault_addr` out 32: `in_addr` of the faulting op.

## Operation
- FSM states: IDLE, REQ, RESP. `in_ready` = (state == IDLE) & `rst_n`.
- Accept, non-memory op (`in_memread` = `in_memwrite` = 0):
  - State stays IDLE.
  - `wb_data` <= `in_alu_z`; rd and regwrite are passed through.
  - Back-to-back throughput is 1 op per cycle.
- Accept, memory op:
  - Latch `dmem_addr` = {`in_addr`[31:2], 2'b00}, plus be, wdata, we, rd and funct3.
  - Go to REQ.
- REQ:
  - `dmem_req` = 1; addr, we, be and wdata are held stable until `dmem_gnt`.
  - Store with gnt: go to IDLE, emit wb with regwrite 0.
  - Load with gnt: go to RESP.
- RESP: wait for `dmem_rvalid`, then go to IDLE and emit wb with the extracted data.
- Store lanes:
  - SB: `be` = 1 << addr[1:0]; wdata = {4{rs2[7:0]}}.
  - SH: `be` = addr[1] ? 1100 : 0011; wdata = {2{rs2[15:0]}}.
  - SW: `be` = 1111; wdata = rs2.
- Load extract:
  - Byte is selected by addr[1:0]; half is selected by addr[1].
  - B/H are sign-extended; BU/HU are zero-extended; W is passed whole.
  - Load `dmem_be` mirrors the store encoding.
- Illegal ops fault with no bus access, i.e. a wb pulse with `wb_fault` = 1:
  - `in_memread` & `in_memwrite` both set.
  - Memory funct3 of 011, 110 or 111.
- `dmem_rvalid` in IDLE or REQ is ignored. `dmem_gnt` outside REQ is ignored.

## Timing
- Reset values:
  - State IDLE; `in_ready` 0 while `rst_n` = 0.
  - `dmem_req`, `dmem_we`, `wb_valid`, `wb_regwrite`, `wb_fault` = 0.
  - `dmem_addr`, `dmem_be`, `dmem_wdata`, `wb_rd`, `wb_data`, `wb_fault_addr` = 0.
- All outputs except `in_ready` are registered.
- Non-memory or faulting op accepted at cycle 0 -> `wb_valid` at cycle 1.
- Memory op accepted at cycle 0 -> `dmem_req` = 1 from cycle 1.
- Gnt at cycle k -> `dmem_req` = 0 at k+1.
  - Store: `wb_valid` at k+1.
  - Load: `wb_valid` at r+1, where r is the `dmem_rvalid` cycle; r >= k+1. Minimum load latency is 3 cycles.
- `in_ready` returns to 1 in the cycle `wb_valid` is 1, so a new op can be accepted that cycle.
- `wb_valid` is high for exactly one cycle per accepted op. The writeback consumer is always ready.
- Reset mid-operation:
  - Next edge forces IDLE and drops `dmem_req` and `wb_valid`.
  - The pending op is discarded; no wb is emitted.
  - A late `rvalid` after reset is ignored.

## Configuration
- `MEM_STAGE_MISALIGN_TRAP_EN` defined:
  - Misaligned cases are halfword with addr[0] = 1, and word with addr[1:0] != 0.
  - These issue no bus access and emit wb next cycle with `wb_fault` = 1, `wb_fault_addr` = `in_addr`, regwrite 0.
- Undefined:
  - Offending low address bits are ignored: H uses addr[1] only; W uses the aligned word.
  - `wb_fault` is set only for illegal ops.

## Test plan
- ALU ops with Z = 0x11, 0x22, 0x33 on consecutive cycles, rd = 1, 2, 3 -> wb_valid on 3 consecutive cycles with matching data/rd; `dmem_req` never asserted.
- SB: addr 0x1002, rs2 0xAABBCCDD, gnt on first REQ cycle -> `dmem_addr` 0x1000, be 0100, wdata 0xDDDDDDDD, we 1; wb_valid 2 cycles after accept, regwrite 0.
- LB: addr 0x2003, gnt delayed 2 cycles, rdata 0x80FF7F01 with rvalid 3 cycles after gnt -> wb_data 0xFFFFFF80. Same access as LBU -> 0x00000080. `in_ready` is 0 throughout until the wb cycle.
- LH: addr 0x2002, rdata 0x8001ABCD -> wb_data 0xFFFF8001. LW: addr 0x2000 -> 0x8001ABCD.
- LW at 0x3001 -> with macro: wb_fault 1, fault_addr 0x3001, no `dmem_req`. Without macro: `dmem_addr` 0x3000, normal load.
- Assert `rst_n` = 0 for one cycle while in RESP, then send rvalid -> no wb_valid; `dmem_req` 0; next op accepted normally.
